// File: rtl/fetch_pkg.sv
// Shared types and helpers for the fetch PC sequencer.
// Optional perf counters are enabled by FETCH_PERF_COUNT_EN.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        STALL
    } fetch_state_t;

    localparam logic [31:0] PC_STEP = 32'd4;

    // Sign-extend before shifting so no immediate bits are lost.
    function automatic logic [31:0] sext_word_offset(
        input logic [23:0] imm
    );
        return {{6{imm[23]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_branch_target.sv
// Branch target adder: carried PC+4, word offset, plus one more step.
module fetch_branch_target
    import fetch_pkg::*;
(
    input  logic [23:0] branch_imm,
    input  logic [31:0] branch_pc,
    output logic [31:0] target
);

    assign target = branch_pc
                  + sext_word_offset(branch_imm)
                  + PC_STEP;

endmodule

// File: rtl/fetch_pc_sequencer.sv
// PC owner and imem request sequencer feeding the IF/ID register.
// Define FETCH_PERF_COUNT_EN to add branch/squash perf counters.
module fetch_pc_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef FETCH_PERF_COUNT_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [23:0] branch_imm,
    input  logic [31:0] branch_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        flush
`ifdef FETCH_PERF_COUNT_EN
    ,
    output logic [CNT_W-1:0] perf_branches,
    output logic [CNT_W-1:0] perf_squashed
`endif
);

    fetch_state_t state;
    fetch_state_t state_next;

    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] held_instr;
    logic [31:0] held_next;
    logic [31:0] pend_target;
    logic [31:0] pend_next;
    logic [31:0] target;
    logic        fetch_hit;

    fetch_branch_target u_target (
        .branch_imm (branch_imm),
        .branch_pc  (branch_pc),
        .target     (target)
    );

    assign fetch_hit = (state == FETCH) && imem_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        held_next  = held_instr;
        pend_next  = pend_target;
        case (state)
            IDLE: begin
                state_next = FETCH;
            end
            FETCH: begin
                if (imem_ack) begin
                    if (branch_taken) begin
                        pc_next = target;
                    end else begin
                        pc_next = pc + PC_STEP;
                        if (freeze) begin
                            held_next  = imem_rdata;
                            state_next = STALL;
                        end
                    end
                end else if (branch_taken) begin
                    pend_next  = target;
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // The old request must complete before redirecting.
                if (imem_ack) begin
                    pc_next    = branch_taken ? target : pend_target;
                    state_next = FETCH;
                end else if (branch_taken) begin
                    pend_next = target;
                end
            end
            STALL: begin
                if (branch_taken) begin
                    pc_next    = target;
                    state_next = FETCH;
                end else if (!freeze) begin
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        imem_req  = (state == FETCH) || (state == DRAIN);
        imem_addr = pc;
        flush     = branch_taken;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            held_instr  <= '0;
            pend_target <= '0;
        end else begin
            pc          <= pc_next;
            held_instr  <= held_next;
            pend_target <= pend_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_valid <= 1'b0;
            if_instr <= '0;
            if_pc    <= '0;
        end else if (branch_taken) begin
            if_valid <= 1'b0;
        end else if (!freeze) begin
            if (fetch_hit) begin
                if_valid <= 1'b1;
                if_instr <= imem_rdata;
                if_pc    <= pc + PC_STEP;
            end else if (state == STALL) begin
                if_valid <= 1'b1;
                if_instr <= held_instr;
                if_pc    <= pc;
            end else begin
                if_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_COUNT_EN
    logic squash;

    assign squash = imem_ack
                  && ((fetch_hit && branch_taken)
                   || (state == DRAIN));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_branches <= '0;
            perf_squashed <= '0;
        end else begin
            if (branch_taken && (perf_branches != '1))
                perf_branches <= perf_branches + CNT_W'(1);
            if (squash && (perf_squashed != '1))
                perf_squashed <= perf_squashed + CNT_W'(1);
        end
    end
`endif

endmodule
